// File: rtl/stream_mux_n.sv
// Registered N-channel stream multiplexer with valid/ready handshakes and fixed-select or round-robin arbitration.
// Define STREAM_MUX_N_CNT_EN to add the 16-bit output handshake counter port xfer_cnt.
module stream_mux_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    output logic [SELW-1:0]        out_ch,
    input  logic                   out_ready
`ifdef STREAM_MUX_N_CNT_EN
    ,
    output logic [15:0]            xfer_cnt
`endif
);

    localparam int unsigned CNTW = 16;

    logic             free_c;
    logic             grant_vld_c;
    logic [SELW-1:0]  grant_c;
    logic [WIDTH-1:0] grant_data_c;
    logic             load_c;

    logic [SELW-1:0]  ptr_q,       ptr_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic             out_valid_q, out_valid_d;

    // Arbitration: fixed select or first valid channel scanning from ptr.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        grant_vld_c  = 1'b0;
        grant_c      = '0;
        if (mode) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                idx = 32'(ptr_q) + i;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                if (!grant_vld_c && in_valid[SELW'(idx)]) begin
                    grant_vld_c = 1'b1;
                    grant_c     = SELW'(idx);
                end
            end
        end else begin
            // sel values at or above NCH match no channel, so nothing is granted.
            for (int unsigned k = 0; k < NCH; k++) begin
                if (sel == SELW'(k) && in_valid[k]) begin
                    grant_vld_c = 1'b1;
                    grant_c     = SELW'(k);
                end
            end
        end
    end

    always_comb begin
        grant_data_c = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (grant_c == SELW'(k)) begin
                grant_data_c = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign free_c = !out_valid_q || out_ready;
    assign load_c = free_c && grant_vld_c;

    always_comb begin
        in_ready = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            in_ready[k] = rst_n && load_c && (grant_c == SELW'(k));
        end
    end

    // Output register and round-robin pointer next state.
    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (free_c) begin
            out_valid_d = grant_vld_c;
            if (grant_vld_c) begin
                out_data_d = grant_data_c;
                out_ch_d   = grant_c;
                if (mode) begin
                    ptr_d = (32'(grant_c) == NCH - 1) ? '0 : grant_c + SELW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

`ifdef STREAM_MUX_N_CNT_EN
    logic [CNTW-1:0] xfer_cnt_q, xfer_cnt_d;

    // Output handshakes, wrapping naturally at 16 bits.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q + CNTW'(out_valid_q && out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
